// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - byte-frame command parser that drives the ALU and returns its 16-bit result as two TX bytes
module alu_cmd_ctrl #(
    parameter int          TIMEOUT  = 8,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    input  logic [15:0] ALU_OUT,
    input  logic        OUT_Valid,
    input  logic        FIFO_FULL,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    output logic        CTRL_BUSY
);

    localparam int                CNT_W    = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]        CMD_FULL = 8'hCC;
    localparam logic [7:0]        CMD_REUSE = 8'hDD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_ALU_GO,
        S_ALU_WAIT,
        S_SEND_LO,
        S_SEND_HI,
        S_SEND_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        alu_a_q, alu_a_d;
    logic [7:0]        alu_b_q, alu_b_d;
    logic [3:0]        alu_fun_q, alu_fun_d;
    logic [15:0]       result_q, result_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              send_st;
    logic              tx_vld;

    // The TX strobe must react to FIFO_FULL in the same cycle, so it stays combinational.
    assign send_st = (state_q == S_SEND_LO) || (state_q == S_SEND_HI) || (state_q == S_SEND_ERR);
    assign tx_vld  = send_st && !FIFO_FULL;

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_fun_d = alu_fun_q;
        result_d  = result_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_FULL) begin
                        state_d = S_GET_A;
                    end else if (RX_P_DATA == CMD_REUSE) begin
                        state_d = S_GET_FUN;
                    end
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    alu_a_d = RX_P_DATA;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    alu_b_d = RX_P_DATA;
                    state_d = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[3:0];
                    if (RX_P_DATA[3:0] == 4'hF) begin
                        tx_data_d = ERR_BYTE;
                        state_d   = S_SEND_ERR;
                    end else begin
                        state_d = S_ALU_GO;
                    end
                end
            end
            S_ALU_GO: begin
                cnt_d   = '0;
                state_d = S_ALU_WAIT;
            end
            S_ALU_WAIT: begin
                // A result arriving on the terminal count still beats the timeout.
                if (OUT_Valid) begin
                    result_d  = ALU_OUT;
                    tx_data_d = ALU_OUT[7:0];
                    state_d   = S_SEND_LO;
                end else if (cnt_q == CNT_TERM) begin
                    tx_data_d = ERR_BYTE;
                    state_d   = S_SEND_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND_LO: begin
                if (tx_vld) begin
                    tx_data_d = result_q[15:8];
                    state_d   = S_SEND_HI;
                end
            end
            S_SEND_HI, S_SEND_ERR: begin
                if (tx_vld) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= '0;
            result_q  <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_fun_q <= alu_fun_d;
            result_q  <= result_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;
    assign ALU_EN    = (state_q == S_ALU_GO);
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld;
    assign CTRL_BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed bench for alu_cmd_ctrl with a behavioural ALU and TX byte scoreboard
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [15:0] ALU_OUT;
    logic        OUT_Valid;
    logic        FIFO_FULL = 1'b0;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CTRL_BUSY;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int en_count = 0;
    int last_en = 0;
    int last_tx = 0;
    int prev_tx = 0;
    int alu_lat = 0;
    int pend = 0;
    int eb = 0;
    logic force_invalid = 1'b0;
    logic [7:0] exp_q[$];

    alu_cmd_ctrl #(.TIMEOUT(8), .ERR_BYTE(8'hEE)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CTRL_BUSY(CTRL_BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'h0: alu_f = {8'h00, a} + {8'h00, b};
            4'h1: alu_f = {8'h00, a} - {8'h00, b};
            4'h2: alu_f = {8'h00, a} * {8'h00, b};
            4'h3: alu_f = (b != 0) ? {8'h00, a / b} : 16'h0000;
            4'h4: alu_f = {8'h00, a & b};
            default: alu_f = {8'h00, a | b};
        endcase
    endfunction

    // Behavioural ALU with programmable result latency and optional result suppression.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT_Valid <= 1'b0;
            ALU_OUT   <= 16'h0000;
            pend      <= 0;
        end else begin
            OUT_Valid <= 1'b0;
            if (ALU_EN) begin
                ALU_OUT <= alu_f(ALU_A, ALU_B, ALU_FUN);
                if (alu_lat == 0) OUT_Valid <= !force_invalid;
                else pend <= alu_lat;
            end else if (pend != 0) begin
                pend <= pend - 1;
                if (pend == 1) OUT_Valid <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge CLK) begin
        if (ALU_EN) begin
            en_count = en_count + 1;
            last_en  = cyc;
        end
        if (TX_D_VLD) begin
            chk("tx_while_full", {31'b0, FIFO_FULL}, 32'd0);
            prev_tx = last_tx;
            last_tx = cyc;
            chk("tx_expected_pending", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("tx_byte", {24'b0, TX_P_DATA}, {24'b0, exp_q.pop_front()});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic send_cc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        send_byte(8'hCC);
        send_byte(a);
        send_byte(b);
        send_byte(f);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (!CTRL_BUSY && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, {31'b0, done}, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #12;
        chk("reset_outputs", {1'b0, ALU_A, ALU_B, ALU_FUN, TX_P_DATA, TX_D_VLD, CTRL_BUSY, ALU_EN}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;

        // Basic add: minimum latency and busy drop.
        eb = en_count;
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        send_cc(8'h05, 8'h03, 8'h00);
        chk("load_a", {24'b0, ALU_A}, 32'h05);
        chk("load_b", {24'b0, ALU_B}, 32'h03);
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("busy_in_send_hi", {31'b0, CTRL_BUSY}, 32'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("busy_dropped", {31'b0, CTRL_BUSY}, 32'd0);
        chk("en_pulse_add", en_count - eb, 1);
        chk("latency_add", last_tx - last_en, 3);
        chk("consecutive_bytes", last_tx - prev_tx, 1);
        @(posedge CLK); #1;

        // Multiply FF*FF.
        exp_q.push_back(8'h01); exp_q.push_back(8'hFE);
        send_cc(8'hFF, 8'hFF, 8'h02);
        wait_idle("idle_mul");

        // Reuse stored operands, then back-to-back full frame.
        eb = en_count;
        exp_q.push_back(8'hFE); exp_q.push_back(8'h01);
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        send_byte(8'hDD);
        send_byte(8'h00);
        chk("reuse_a", {24'b0, ALU_A}, 32'hFF);
        chk("reuse_b", {24'b0, ALU_B}, 32'hFF);
        repeat (4) @(posedge CLK);
        #1;
        send_cc(8'h05, 8'h03, 8'h00);
        wait_idle("idle_b2b");
        chk("en_pulse_b2b", en_count - eb, 2);

        // Illegal function (upper nibble ignored).
        eb = en_count;
        exp_q.push_back(8'hEE);
        send_cc(8'h01, 8'h02, 8'hAF);
        wait_idle("idle_illegal");
        chk("no_en_illegal", en_count - eb, 0);
        chk("fun_illegal", {28'b0, ALU_FUN}, 32'hF);

        // Timeout with no OUT_Valid.
        force_invalid = 1'b1;
        eb = en_count;
        exp_q.push_back(8'hEE);
        send_cc(8'h01, 8'h01, 8'h00);
        wait_idle("idle_timeout");
        force_invalid = 1'b0;
        chk("en_pulse_timeout", en_count - eb, 1);
        chk("latency_timeout", last_tx - last_en, 9);

        // OUT_Valid on the terminal count: result wins.
        alu_lat = 7;
        exp_q.push_back(8'h05); exp_q.push_back(8'h00);
        send_cc(8'h02, 8'h03, 8'h00);
        wait_idle("idle_terminal");
        chk("latency_terminal", last_tx - last_en, 10);

        // Stray IDLE byte and bytes during ALU_WAIT are dropped.
        alu_lat = 3;
        eb = en_count;
        send_byte(8'h41);
        exp_q.push_back(8'h05); exp_q.push_back(8'h00);
        send_cc(8'h02, 8'h03, 8'h00);
        @(posedge CLK); #1;
        send_byte(8'hCC);
        send_byte(8'h11);
        wait_idle("idle_stray");
        alu_lat = 0;
        chk("en_pulse_stray", en_count - eb, 1);
        chk("latency_stray", last_tx - last_en, 6);
        chk("a_kept_stray", {24'b0, ALU_A}, 32'h02);

        // FIFO full for 3 cycles in SEND_LO.
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        send_cc(8'h05, 8'h03, 8'h00);
        FIFO_FULL = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_no_vld", {31'b0, TX_D_VLD}, 32'd0);
            chk("stall_data_held", {24'b0, TX_P_DATA}, 32'h08);
            @(posedge CLK); #1;
        end
        FIFO_FULL = 1'b0;
        wait_idle("idle_full");
        chk("latency_full", last_tx - last_en, 6);

        // Reset while stalled in SEND_HI, then a normal frame.
        exp_q.push_back(8'h08);
        send_cc(8'h05, 8'h03, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        FIFO_FULL = 1'b1;
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("reset_mid_send", {1'b0, ALU_A, ALU_B, ALU_FUN, TX_P_DATA, TX_D_VLD, CTRL_BUSY, ALU_EN}, 32'd0);
        chk("lo_sent_before_reset", exp_q.size(), 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        FIFO_FULL = 1'b0;
        @(posedge CLK); #1;
        eb = en_count;
        exp_q.push_back(8'h08); exp_q.push_back(8'h00);
        send_cc(8'h05, 8'h03, 8'h00);
        wait_idle("idle_after_reset");
        chk("en_pulse_after_reset", en_count - eb, 1);
        chk("latency_after_reset", last_tx - last_en, 3);

        repeat (3) @(posedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
